// File: rtl/prm_pipeline_pkg.sv
// Shared constants and helpers for the elastic pipeline register.
// Provides clog2, the occupancy counter width and the default reset value.
package prm_pipeline_pkg;

  localparam logic DEF_RESET_BIT = 1'b0;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Room for 0..DEPTH+1 entries (skid entry included).
  function automatic int cnt_width(input int depth);
    return clog2(depth + 2);
  endfunction

endpackage

// File: rtl/prm_pipeline_stage.sv
// One elastic stage: valid/data registers with load-when-ready behaviour.
// Ports: clk, rst, clr, src_valid/src_data (from upstream), next_ready
// (ready of the downstream side), valid/data (registered stage contents).
module prm_pipeline_stage
  import prm_pipeline_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEF_RESET_BIT}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             next_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic ready;

  // An empty stage always accepts, so bubbles collapse.
  assign ready = ~valid | next_ready;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (ready) begin
      valid <= src_valid;
      // Data only moves with a valid word to avoid needless toggling.
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/prm_pipeline_cc.sv
// Elastic pipeline register: DEPTH stages, valid/ready on both sides,
// synchronous flush (clr) and registered occupancy count.
// Ports: clk, rst, clr, in_valid/in_ready/in_data, out_valid/out_ready/
// out_data, occupancy. Optional macro PRM_PIPELINE_SKID_EN adds a one-entry
// skid buffer ahead of stage 0 so in_ready depends only on registers.
module prm_pipeline_cc
  import prm_pipeline_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEF_RESET_BIT}},
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0][WIDTH-1:0] dat;
  logic [DEPTH-1:0]            nxt;
  logic                        ready0;
  logic                        in_xfer;
  logic                        out_xfer;
  logic                        src_valid;
  logic [WIDTH-1:0]            src_data;

  // Ready chain from the output side back to stage 0. nxt[i] is the
  // ready seen downstream of stage i; ready0 is stage 0's own ready.
  always_comb begin
    logic r;
    nxt = '0;
    r   = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      nxt[i] = r;
      r      = ~vld[i] | r;
    end
    ready0 = r;
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

`ifdef PRM_PIPELINE_SKID_EN
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign in_ready  = ~skid_valid & ~rst & ~clr;
  // A parked word always goes first to keep FIFO order.
  assign src_valid = skid_valid | in_xfer;
  assign src_data  = skid_valid ? skid_data : in_data;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      skid_valid <= 1'b0;
      skid_data  <= RESET_VAL;
    end else if (skid_valid) begin
      if (ready0) begin
        skid_valid <= 1'b0;
      end
    end else if (in_xfer && !ready0) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end
`else
  assign in_ready  = ready0 & ~clr & ~rst;
  assign src_valid = in_xfer;
  assign src_data  = in_data;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             sv;
    logic [WIDTH-1:0] sd;
    if (i == 0) begin : g_head
      assign sv = src_valid;
      assign sd = src_data;
    end else begin : g_body
      assign sv = vld[i-1];
      assign sd = dat[i-1];
    end
    prm_pipeline_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .src_valid  (sv),
      .src_data   (sd),
      .next_ready (nxt[i]),
      .valid      (vld[i]),
      .data       (dat[i])
    );
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end
  end

endmodule

// File: tb/tb_prm_pipeline_cc.sv
// Self-checking bench for prm_pipeline_cc: directed cases plus random
// valid/ready traffic against a queue-based scoreboard.
module tb_prm_pipeline_cc;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam logic [WIDTH-1:0] RVAL = 8'hC3;
  localparam int CNT_W = $clog2(DEPTH + 2);
`ifdef PRM_PIPELINE_SKID_EN
  localparam int SKID = 1;
`else
  localparam int SKID = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;

  logic [WIDTH-1:0] q[$];
  bit               started   = 0;
  bit               chk_flush = 0;
  bit               chk_stall = 0;
  logic [WIDTH-1:0] held;

  prm_pipeline_cc #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (RVAL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor. The model keeps only the in-flight words; the
  // block can take a word unless every slot is full and the output stalls.
  always @(negedge clk) begin
    bit flush;
    bit exp_rdy;
    int cnt;
    flush = rst | clr;
    cnt   = q.size();
    if (SKID != 0) begin
      exp_rdy = (cnt <= DEPTH);
    end else begin
      exp_rdy = (cnt < DEPTH) || out_ready;
    end
    exp_rdy = exp_rdy & ~flush;
    check("in_ready", int'(in_ready), int'(exp_rdy));
    if (started) begin
      check("occupancy", int'(occupancy), cnt);
      if (chk_flush) begin
        check("flush_out_valid", int'(out_valid), 0);
        check("flush_out_data", int'(out_data), int'(RVAL));
      end
      if (chk_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(held));
      end
      if (out_valid && out_ready) begin
        check("queue_nonempty", int'(cnt > 0), 1);
        if (cnt > 0) begin
          check("out_word", int'(out_data), int'(q.pop_front()));
        end
      end
    end
    if (in_valid && exp_rdy) begin
      q.push_back(in_data);
      n_acc++;
    end
    if (flush) begin
      q.delete();
    end
    chk_flush = flush;
    chk_stall = out_valid & ~out_ready & ~flush;
    held      = out_data;
    if (rst) begin
      started = 1;
    end
  end

  initial begin
    int lat;
    int n_out;
    int acc;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), int'(RVAL));
    check("rst_occupancy", int'(occupancy), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Streaming 0x01..0x10
    out_ready = 1'b1;
    lat = -1;
    n_out = 0;
    for (int k = 0; k < 40; k++) begin
      in_valid = (k < 16);
      in_data  = WIDTH'(k + 1);
      tick();
      if (out_valid) n_out++;
      if (lat < 0 && out_valid) lat = k + 1;
      if (k == 7) check("stream_occupancy", int'(occupancy), DEPTH);
    end
    check("stream_latency", lat, DEPTH);
    check("stream_words", n_out, 16);

    // Backpressure fill
    out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(8'hA0 + acc);
      #1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("fill_accepts", acc, DEPTH + SKID);
    check("fill_in_ready", int'(in_ready), 0);
    check("fill_out_data", int'(out_data), 'hA0);
    check("fill_occupancy", int'(occupancy), DEPTH + SKID);
    out_ready = 1'b1;
    repeat (DEPTH + SKID + 3) tick();
    check("drain_occupancy", int'(occupancy), 0);

    // Bubble collapse
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = (k == 0 || k == 3);
      in_data  = (k == 0) ? 8'h31 : 8'h32;
      #1;
      check("bubble_in_ready", int'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("bubble_occupancy", int'(occupancy), 2);
    check("bubble_out_data", int'(out_data), 'h31);

    // Flush mid-stream
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h55;
    #1;
    check("clr_in_ready", int'(in_ready), 0);
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    #1;
    check("clr_out_valid", int'(out_valid), 0);
    check("clr_occupancy", int'(occupancy), 0);
    check("clr_out_data", int'(out_data), int'(RVAL));
    out_ready = 1'b1;
    repeat (5) tick();
    check("clr_no_55", int'(out_valid), 0);

    // Reset mid-operation, with clr asserted too
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(8'h70 + k);
      tick();
    end
    rst = 1'b1;
    clr = 1'b1;
    #1;
    check("rstmid_in_ready", int'(in_ready), 0);
    tick();
    rst = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rstmid_out_valid", int'(out_valid), 0);
    check("rstmid_occupancy", int'(occupancy), 0);
    check("rstmid_out_data", int'(out_data), int'(RVAL));
    check("rstmid_in_ready_after", int'(in_ready), 1);

    // Randomized traffic
    n_acc = 0;
    for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
      in_valid  = ($urandom % 10) < 7;
      in_data   = WIDTH'($urandom);
      out_ready = ($urandom % 10) < 6;
      clr       = ($urandom % 1000) == 0;
      tick();
    end
    clr = 1'b0;
    check("random_words", int'(n_acc >= 10000), 1);

    // Final drain
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + SKID + 4) tick();
    check("end_occupancy", int'(occupancy), 0);
    check("end_out_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
